// File: rtl/intc_vec.sv
// Vectored interrupt controller: latches done edges into pending bits, arbitrates among
// unmasked sources and presents one registered request plus handler address to the core.
module intc_vec #(
  parameter int unsigned       NUM_SRC    = 8,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_1000,
  parameter int unsigned       VEC_STRIDE = 4,
  parameter int unsigned       RR_MODE    = 0,
  parameter int unsigned       ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] done,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               iack,
  input  logic               ovf_clr,
  output logic               irq,
  output logic [ADDR_W-1:0]  PC_handler,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAssert  = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 irq_q, irq_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]   done_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   overrun_q, overrun_d;

  logic [NUM_SRC-1:0]   rise, elig, clr, rot;
  logic [2*NUM_SRC-1:0] dbl;
  logic [ID_W:0]        rr_sum;
  logic [ID_W-1:0]      win_fp, win_rr, win;
  logic                 ack;

  // Index of the lowest set bit; 0 when the vector is empty (caller guards with |v).
  function automatic logic [ID_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (v[i] && !found) begin
        r     = ID_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign rise = done & ~done_q;
  assign elig = pending_q & ~mask;
  assign ack  = (state_q == StAssert) && iack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      clr[i] = ack && (id_q == ID_W'(i));
    end
  end

  // Round-robin: rotate so rr_ptr lands at bit 0, pick lowest, then rotate the index back.
  always_comb begin
    dbl    = {elig, elig} >> rr_ptr_q;
    rot    = dbl[NUM_SRC-1:0];
    rr_sum = {1'b0, rr_ptr_q} + {1'b0, lowest(rot)};
    if (rr_sum >= (ID_W+1)'(NUM_SRC)) begin
      rr_sum = rr_sum - (ID_W+1)'(NUM_SRC);
    end
    win_rr = rr_sum[ID_W-1:0];
    win_fp = lowest(elig);
    win    = (RR_MODE != 0) ? win_rr : win_fp;
  end

  // A rise on the bit being acked re-arms it rather than counting as an overrun.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = (ovf_clr ? '0 : overrun_q) | (rise & pending_q & ~clr);
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    pc_d     = pc_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d = StAssert;
          irq_d   = 1'b1;
          id_d    = win;
          pc_d    = VEC_BASE + ADDR_W'(win) * ADDR_W'(VEC_STRIDE);
        end
      end
      StAssert: begin
        if (iack) begin
          state_d  = StRelease;
          irq_d    = 1'b0;
          rr_ptr_d = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
        end
      end
      StRelease: begin
        if (!iack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      irq_q     <= 1'b0;
      pc_q      <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      done_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pc_q      <= pc_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      done_q    <= done;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq        = irq_q;
  assign PC_handler = pc_q;
  assign irq_id     = id_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_intc_vec.sv
// Directed bench: a fixed-priority and a round-robin controller share the same stimulus.
module tb_intc_vec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  done = '0;
  logic [3:0]  mask = '0;
  logic        iack = 1'b0;
  logic        ovf_clr = 1'b0;

  logic        irq0, irq1;
  logic [31:0] pc0, pc1;
  logic [1:0]  id0, id1;
  logic [3:0]  pend0, pend1;
  logic [3:0]  ovf0, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  intc_vec #(
    .NUM_SRC(4), .ADDR_W(32), .VEC_BASE(32'h1000), .VEC_STRIDE(4), .RR_MODE(0), .ID_W(2)
  ) u_fp (
    .clk(clk), .rst(rst), .done(done), .mask(mask), .iack(iack), .ovf_clr(ovf_clr),
    .irq(irq0), .PC_handler(pc0), .irq_id(id0), .pending(pend0), .overrun(ovf0)
  );

  intc_vec #(
    .NUM_SRC(4), .ADDR_W(32), .VEC_BASE(32'h1000), .VEC_STRIDE(4), .RR_MODE(1), .ID_W(2)
  ) u_rr (
    .clk(clk), .rst(rst), .done(done), .mask(mask), .iack(iack), .ovf_clr(ovf_clr),
    .irq(irq1), .PC_handler(pc1), .irq_id(id1), .pending(pend1), .overrun(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full ack: one cycle high, then two low so the next grant is already visible.
  task automatic ack_cycle();
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    step(2);
  endtask

  initial begin
    logic [3:0] exp_pend;

    // Reset
    #1 rst = 1'b0;
    #1;
    check("rst_irq", {31'b0, irq0}, 32'h0);
    check("rst_pc", pc0, 32'h0);
    check("rst_id", {30'b0, id0}, 32'h0);
    check("rst_pend", {28'b0, pend0}, 32'h0);
    check("rst_ovf", {28'b0, ovf0}, 32'h0);
    step(2);
    rst = 1'b1;
    step(1);

    // 1: all four sources, fixed priority order
    done = 4'hF;
    step(1);
    check("t1_pend_set", {28'b0, pend0}, 32'hF);
    check("t1_latency_irq", {31'b0, irq0}, 32'h0);
    done = 4'h0;
    step(1);
    for (int k = 0; k < 4; k++) begin
      exp_pend = 4'hF << k;
      check("t1_irq", {31'b0, irq0}, 32'h1);
      check("t1_pc", pc0, 32'h1000 + 4 * k);
      check("t1_id", {30'b0, id0}, k);
      check("t1_rr_id", {30'b0, id1}, k);
      check("t1_pend", {28'b0, pend0}, {28'b0, exp_pend});
      iack = 1'b1;
      step(1);
      exp_pend = 4'hF << (k + 1);
      check("t1_irq_ack", {31'b0, irq0}, 32'h0);
      check("t1_pend_ack", {28'b0, pend0}, {28'b0, exp_pend});
      iack = 1'b0;
      step(2);
    end
    check("t1_irq_done", {31'b0, irq0}, 32'h0);
    ack_cycle();
    check("t1_5th_irq", {31'b0, irq0}, 32'h0);
    check("t1_5th_pend", {28'b0, pend0}, 32'h0);

    // 2: ack src1, then src0+src2 together; RR resumes after src1
    done = 4'b0010;
    step(1);
    done = 4'b0000;
    step(1);
    check("t2_id_a", {30'b0, id1}, 32'h1);
    ack_cycle();
    done = 4'b0101;
    step(1);
    done = 4'b0000;
    step(1);
    check("t2_rr_pc1", pc1, 32'h1008);
    check("t2_rr_id1", {30'b0, id1}, 32'h2);
    check("t2_fp_pc1", pc0, 32'h1000);
    ack_cycle();
    check("t2_rr_pc2", pc1, 32'h1000);
    check("t2_fp_pc2", pc0, 32'h1008);
    ack_cycle();
    check("t2_pend_end", {28'b0, pend1}, 32'h0);

    // 3: masked source records pending but is not granted until unmasked
    mask = 4'b0001;
    done = 4'b0001;
    step(1);
    done = 4'b0000;
    step(2);
    check("t3_pend", {28'b0, pend0}, 32'h1);
    check("t3_irq_masked", {31'b0, irq0}, 32'h0);
    mask = 4'b0000;
    step(2);
    check("t3_irq", {31'b0, irq0}, 32'h1);
    check("t3_pc", pc0, 32'h1000);
    check("t3_rr_pc", pc1, 32'h1000);
    ack_cycle();

    // 4: overrun
    done = 4'b0100;
    step(1);
    done = 4'b0000;
    step(1);
    done = 4'b0100;
    step(1);
    done = 4'b0000;
    step(1);
    check("t4_ovf", {28'b0, ovf0}, 32'h4);
    check("t4_pend", {28'b0, pend0}, 32'h4);
    check("t4_id", {30'b0, id0}, 32'h2);
    iack = 1'b1;
    step(1);
    check("t4_pend_ack", {28'b0, pend0}, 32'h0);
    iack = 1'b0;
    step(2);
    check("t4_ovf_sticky", {28'b0, ovf0}, 32'h4);
    check("t4_irq_none", {31'b0, irq0}, 32'h0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", {28'b0, ovf0}, 32'h0);

    // 5: grant held while a new source arrives; long iack
    done = 4'b1000;
    step(1);
    done = 4'b0000;
    step(1);
    check("t5_pc3", pc0, 32'h100C);
    done = 4'b0001;
    step(1);
    done = 4'b0000;
    check("t5_hold_pc", pc0, 32'h100C);
    check("t5_hold_pend", {28'b0, pend0}, 32'h9);
    step(1);
    check("t5_hold_id", {30'b0, id0}, 32'h3);
    iack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t5_iack_irq", {31'b0, irq0}, 32'h0);
    end
    iack = 1'b0;
    step(1);
    check("t5_rel_irq", {31'b0, irq0}, 32'h0);
    step(1);
    check("t5_next_pc", pc0, 32'h1000);
    check("t5_next_rr", pc1, 32'h1000);

    // 6: async reset mid-ASSERT with an overrun outstanding
    done = 4'b0001;
    step(1);
    done = 4'b0000;
    step(1);
    check("t6_ovf_pre", {28'b0, ovf0}, 32'h1);
    #3 rst = 1'b0;
    done = 4'b0010;
    #1;
    check("t6_irq", {31'b0, irq0}, 32'h0);
    check("t6_pend", {28'b0, pend0}, 32'h0);
    check("t6_ovf", {28'b0, ovf0}, 32'h0);
    check("t6_pc", pc0, 32'h0);
    step(1);
    rst = 1'b1;
    step(1);
    check("t6_rel_irq1", {31'b0, irq0}, 32'h0);
    check("t6_rel_pend", {28'b0, pend0}, 32'h2);
    step(1);
    check("t6_rel_irq2", {31'b0, irq0}, 32'h1);
    check("t6_rel_pc", pc0, 32'h1004);
    check("t6_rel_rr_pc", pc1, 32'h1004);
    done = 4'b0000;
    step(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
